// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs symbolic instruction records into MIPS
// machine words and writes them to instruction memory from word address 0.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_alu,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [2:0] K_R   = 3'd0;
  localparam logic [2:0] K_LW  = 3'd1;
  localparam logic [2:0] K_SW  = 3'd2;
  localparam logic [2:0] K_BEQ = 3'd3;
  localparam logic [2:0] K_END = 3'd4;

  localparam logic [1:0] E_KIND = 2'd1;
  localparam logic [1:0] E_ALU  = 2'd2;
  localparam logic [1:0] E_OVF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic                mem_full;

  function automatic logic alu_ok(input logic [2:0] alu);
    case (alu)
      3'b010, 3'b110, 3'b000, 3'b001, 3'b111: alu_ok = 1'b1;
      default:                                alu_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] funct_of(input logic [2:0] alu);
    case (alu)
      3'b010:  funct_of = 6'b100000;
      3'b110:  funct_of = 6'b100010;
      3'b000:  funct_of = 6'b100100;
      3'b001:  funct_of = 6'b100101;
      3'b111:  funct_of = 6'b101010;
      default: funct_of = 6'b000000;
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [2:0]  kind,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [2:0]  alu,
                                         input logic [15:0] imm);
    case (kind)
      K_LW:    encode = {6'b100011, rs, rt, imm};
      K_SW:    encode = {6'b101011, rs, rt, imm};
      K_BEQ:   encode = {6'b000100, rs, rt, imm};
      default: encode = {6'b000000, rs, rt, rd, 5'b00000, funct_of(alu)};
    endcase
  endfunction

  // count never exceeds DEPTH, so its MSB alone means "memory full"
  assign mem_full = count_q[ADDR_W];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    code_d  = code_q;
    if (start) begin
      state_d = S_LOAD;
      addr_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = 2'd0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            if (in_kind > K_END) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
              code_d  = E_KIND;
            end else if (in_kind == K_R && !alu_ok(in_alu)) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
              code_d  = E_ALU;
            end else if (in_kind == K_END) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (mem_full) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
              code_d  = E_OVF;
            end else begin
              state_d = S_WRITE;
              wdata_d = encode(in_kind, in_rs, in_rt, in_rd, in_alu, in_imm);
            end
          end
        end
        S_WRITE: begin
          if (imem_ack) begin
            state_d = S_LOAD;
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (ADDR_W=2): directed scenarios plus randomized
// sessions checked against a record-level reference model.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [2:0]    in_alu;
  logic [15:0]   in_imm;
  logic          imem_we;
  logic          imem_ack;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  int m_count;
  int m_addr;
  bit m_active;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_alu(in_alu), .in_imm(in_imm), .imem_we(imem_we),
    .imem_ack(imem_ack), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Funct code for an ALU control value, -1 when the value is not an R-type op.
  function automatic int ref_funct(input int alu);
    case (alu)
      2:       return 32;
      6:       return 34;
      0:       return 36;
      1:       return 37;
      7:       return 42;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                           input int rd, input int alu, input int imm);
    longint op, w;
    case (kind)
      1:       op = 35;
      2:       op = 43;
      3:       op = 4;
      default: op = 0;
    endcase
    if (kind == 0)
      w = rs * 2097152 + rt * 65536 + rd * 2048 + ref_funct(alu);
    else
      w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
    return w[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_code"}, err_code, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_count  = 0;
    m_addr   = 0;
    m_active = 1'b1;
    chk("start_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_code", err_code, 0);
    chk("start_count", count, 0);
    chk("start_addr", imem_addr, 0);
  endtask

  // Present one record while in LOAD (called just after a negedge), then
  // follow its outcome; ack arrives ack_dly cycles after imem_we rises.
  task automatic do_record(input int kind, input int rs, input int rt, input int rd,
                           input int alu, input int imm, input int ack_dly);
    logic [31:0] w;
    int code;
    code = 0;
    if (kind > 4)                              code = 1;
    else if (kind == 0 && ref_funct(alu) < 0)  code = 2;
    else if (kind != 4 && m_count == DEPTH)    code = 3;
    w = ref_word(kind, rs, rt, rd, alu, imm);
    chk("rec_ready", in_ready, 1);
    in_valid = 1'b1;
    in_kind  = 3'(kind);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_alu   = 3'(alu);
    in_imm   = 16'(imm);
    @(negedge clk);
    in_valid = 1'b0;
    if (code != 0) begin
      chk("err_flag", err, 1);
      chk("err_code", err_code, code);
      chk("err_done", done, 0);
      chk("err_we", imem_we, 0);
      chk("err_busy", busy, 0);
      chk("err_count", count, m_count);
      m_active = 1'b0;
    end else if (kind == 4) begin
      chk("done_flag", done, 1);
      chk("done_err", err, 0);
      chk("done_we", imem_we, 0);
      chk("done_busy", busy, 0);
      chk("done_count", count, m_count);
      chk("done_addr", imem_addr, m_addr);
      m_active = 1'b0;
    end else begin
      chk("wr_we", imem_we, 1);
      chk("wr_ready", in_ready, 0);
      chk("wr_addr", imem_addr, m_addr);
      chk("wr_wdata", imem_wdata, w);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        chk("hold_we", imem_we, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_wdata", imem_wdata, w);
        chk("hold_addr", imem_addr, m_addr);
      end
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      m_count++;
      m_addr = (m_addr + 1) % DEPTH;
      chk("ack_we", imem_we, 0);
      chk("ack_count", count, m_count);
      chk("ack_addr", imem_addr, m_addr);
      chk("ack_ready", in_ready, 1);
    end
  endtask

  initial begin
    int kind, alu, r;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    imem_ack = 1'b0;
    in_kind  = '0;
    in_rs    = '0;
    in_rt    = '0;
    in_rd    = '0;
    in_alu   = '0;
    in_imm   = '0;
    m_count  = 0;
    m_addr   = 0;
    m_active = 1'b0;
    #22;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // add, then lw/sw/beq and END
    do_start();
    do_record(0, 1, 2, 3, 2, 0, 0);
    chk("add_word", imem_wdata, 32'h0022_1820);
    do_start();
    do_record(1, 0, 2, 0, 0, 16'h0008, 0);
    chk("lw_word", imem_wdata, 32'h8C02_0008);
    do_record(2, 1, 2, 0, 0, 16'h0004, 1);
    chk("sw_word", imem_wdata, 32'hAC22_0004);
    do_record(3, 1, 2, 0, 0, 16'hFFFF, 0);
    chk("beq_word", imem_wdata, 32'h1022_FFFF);
    do_record(4, 0, 0, 0, 0, 0, 0);
    chk("seq_count", count, 3);

    // slt with slow ack
    do_start();
    do_record(0, 4, 5, 6, 7, 0, 4);
    chk("slt_word", imem_wdata, 32'h0085_302A);

    // illegal alu, illegal kind, then restart clears the error
    do_start();
    do_record(0, 1, 2, 3, 3, 0, 0);
    do_start();
    do_record(6, 1, 2, 3, 2, 0, 0);
    do_start();

    // overflow, and END on a full memory
    for (int i = 0; i < DEPTH; i++) do_record(1, i, i + 1, 0, 0, i * 4, 0);
    do_record(2, 3, 4, 0, 0, 16'h0010, 0);
    chk("ovf_count", count, DEPTH);
    do_start();
    for (int i = 0; i < DEPTH; i++) do_record(0, i, i, i, 6, 0, 0);
    do_record(4, 0, 0, 0, 0, 0, 0);

    // start during WRITE wins over a coincident ack
    do_start();
    do_record(0, 1, 1, 1, 2, 0, 0);
    in_valid = 1'b1;
    in_kind  = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_pre_we", imem_we, 1);
    start    = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    imem_ack = 1'b0;
    chk("abort_we", imem_we, 0);
    chk("abort_addr", imem_addr, 0);
    chk("abort_count", count, 0);
    chk("abort_ready", in_ready, 1);

    // asynchronous reset while writing
    in_valid = 1'b1;
    in_kind  = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst_pre_we", imem_we, 1);
    #1 reset = 1'b1;
    #1 check_all_zero("arst");
    @(negedge clk);
    reset = 1'b0;
    m_active = 1'b0;

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      do_start();
      for (int k = 0; k < 7 && m_active; k++) begin
        r = $urandom_range(0, 99);
        if (r < 80)      kind = $urandom_range(0, 3);
        else if (r < 90) kind = 4;
        else             kind = $urandom_range(5, 7);
        alu = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 5) : 2;
        if (alu == 2) begin
          case ($urandom_range(0, 4))
            0: alu = 2;
            1: alu = 6;
            2: alu = 0;
            3: alu = 1;
            default: alu = 7;
          endcase
        end
        do_record(kind, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), alu, $urandom_range(0, 65535),
                  $urandom_range(0, 3));
      end
      if (m_active) do_record(4, 0, 0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
